// File: rtl/mmx_writeback_controller_pkg.sv
// Shared widths, requester ids and helpers for the MMX writeback controller.
package mmx_pkg;

  localparam int MMX_DATA_WIDTH = 64;
  localparam int MMX_NUM_REGS   = 8;
  localparam int MMX_SEL_WIDTH  = 3;

  typedef enum logic {
    REQ_EX  = 1'b0,
    REQ_MEM = 1'b1
  } req_id_t;

  function automatic logic [3:0] popcount8(input logic [MMX_NUM_REGS-1:0] v);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < MMX_NUM_REGS; i++) begin
      cnt = cnt + {3'b000, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/mmx_writeback_controller_if.sv
// Bundles the writeback requesters, decode allocation/operand lookups and the register-file write port.
interface mmx_writeback_controller_if
  import mmx_pkg::*;
#(
  parameter int DATA_WIDTH = MMX_DATA_WIDTH,
  parameter int NUM_REGS   = MMX_NUM_REGS,
  parameter int SEL_WIDTH  = MMX_SEL_WIDTH
);

  logic                  ex_wb_valid;
  logic [SEL_WIDTH-1:0]  ex_wb_select;
  logic [DATA_WIDTH-1:0] ex_wb_data;
  logic                  ex_wb_ready;

  logic                  mem_wb_valid;
  logic [SEL_WIDTH-1:0]  mem_wb_select;
  logic [DATA_WIDTH-1:0] mem_wb_data;
  logic                  mem_wb_ready;

  logic                  alloc_valid;
  logic [SEL_WIDTH-1:0]  alloc_select;
  logic                  alloc_ready;

  logic [SEL_WIDTH-1:0]  src_a_select;
  logic [SEL_WIDTH-1:0]  src_b_select;
  logic                  src_a_busy;
  logic                  src_b_busy;

  logic [DATA_WIDTH-1:0] writeback_data;
  logic [SEL_WIDTH-1:0]  writeback_select;
  logic                  writeback_enable;

  logic [NUM_REGS-1:0]   pending;
  logic [3:0]            pending_count;

  modport slave (
    input  ex_wb_valid, ex_wb_select, ex_wb_data,
    output ex_wb_ready,
    input  mem_wb_valid, mem_wb_select, mem_wb_data,
    output mem_wb_ready,
    input  alloc_valid, alloc_select,
    output alloc_ready,
    input  src_a_select, src_b_select,
    output src_a_busy, src_b_busy,
    output writeback_data, writeback_select, writeback_enable,
    output pending, pending_count
  );

  modport master (
    output ex_wb_valid, ex_wb_select, ex_wb_data,
    input  ex_wb_ready,
    output mem_wb_valid, mem_wb_select, mem_wb_data,
    input  mem_wb_ready,
    output alloc_valid, alloc_select,
    input  alloc_ready,
    output src_a_select, src_b_select,
    input  src_a_busy, src_b_busy,
    input  writeback_data, writeback_select, writeback_enable,
    input  pending, pending_count
  );

endinterface

// File: rtl/mmx_writeback_controller_scoreboard.sv
// Pending-write scoreboard: set on decode allocation, cleared on writeback, set wins on collision.
module mmx_scoreboard
  import mmx_pkg::*;
#(
  parameter int NUM_REGS  = MMX_NUM_REGS,
  parameter int SEL_WIDTH = MMX_SEL_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alloc_valid,
  input  logic [SEL_WIDTH-1:0] alloc_select,
  output logic                 alloc_ready,
  input  logic                 wb_enable,
  input  logic [SEL_WIDTH-1:0] wb_select,
  input  logic [SEL_WIDTH-1:0] src_a_select,
  input  logic [SEL_WIDTH-1:0] src_b_select,
  output logic                 src_a_busy,
  output logic                 src_b_busy,
  output logic [NUM_REGS-1:0]  pending,
  output logic [3:0]           pending_count
);

  logic [NUM_REGS-1:0] pending_reg;
  logic [NUM_REGS-1:0] pending_next;
  logic [3:0]          count_reg;
  logic                alloc_fire;

  // A retiring write to the same register frees the slot for the new producer.
  assign alloc_ready = ~pending_reg[alloc_select] | (wb_enable & (wb_select == alloc_select));
  assign alloc_fire  = alloc_valid & alloc_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_bit
      logic set_hit;
      logic clr_hit;
      assign set_hit = alloc_fire & (alloc_select == SEL_WIDTH'(gi));
      assign clr_hit = wb_enable & (wb_select == SEL_WIDTH'(gi));
      assign pending_next[gi] = set_hit | (pending_reg[gi] & ~clr_hit);
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_reg <= '0;
      count_reg   <= 4'd0;
    end else begin
      pending_reg <= pending_next;
      count_reg   <= popcount8(pending_next);
    end
  end

  assign pending       = pending_reg;
  assign pending_count = count_reg;
  assign src_a_busy    = pending_reg[src_a_select];
  assign src_b_busy    = pending_reg[src_b_select];

endmodule

// File: rtl/mmx_writeback_controller.sv
// Round-robin writeback arbiter between EX and MEM with a one-cycle registered register-file write port.
module mmx_writeback_controller
  import mmx_pkg::*;
#(
  parameter int DATA_WIDTH = MMX_DATA_WIDTH,
  parameter int NUM_REGS   = MMX_NUM_REGS,
  parameter int SEL_WIDTH  = MMX_SEL_WIDTH
) (
  input  logic                        clk,
  input  logic                        reset,
  mmx_writeback_controller_if.slave   bus
);

  req_id_t               rr_ptr_reg;
  req_id_t               rr_ptr_next;
  logic                  grant_ex;
  logic                  grant_mem;
  logic                  wb_enable_reg;
  logic [SEL_WIDTH-1:0]  wb_select_reg;
  logic [DATA_WIDTH-1:0] wb_data_reg;

  // rr_ptr names the requester that wins the next contended cycle.
  always_comb begin
    grant_ex    = 1'b0;
    grant_mem   = 1'b0;
    rr_ptr_next = rr_ptr_reg;
    if (bus.ex_wb_valid && bus.mem_wb_valid) begin
      if (rr_ptr_reg == REQ_EX) begin
        grant_ex    = 1'b1;
        rr_ptr_next = REQ_MEM;
      end else begin
        grant_mem   = 1'b1;
        rr_ptr_next = REQ_EX;
      end
    end else if (bus.ex_wb_valid) begin
      grant_ex = 1'b1;
    end else if (bus.mem_wb_valid) begin
      grant_mem = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_reg <= REQ_EX;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
    end
  end

  // Data and select hold their last value on idle cycles; only enable drops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_enable_reg <= 1'b0;
      wb_select_reg <= '0;
      wb_data_reg   <= '0;
    end else begin
      wb_enable_reg <= grant_ex | grant_mem;
      if (grant_ex) begin
        wb_select_reg <= bus.ex_wb_select;
        wb_data_reg   <= bus.ex_wb_data;
      end else if (grant_mem) begin
        wb_select_reg <= bus.mem_wb_select;
        wb_data_reg   <= bus.mem_wb_data;
      end
    end
  end

  assign bus.ex_wb_ready      = grant_ex;
  assign bus.mem_wb_ready     = grant_mem;
  assign bus.writeback_enable = wb_enable_reg;
  assign bus.writeback_select = wb_select_reg;
  assign bus.writeback_data   = wb_data_reg;

  mmx_scoreboard #(
    .NUM_REGS  (NUM_REGS),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_scoreboard (
    .clk           (clk),
    .reset         (reset),
    .alloc_valid   (bus.alloc_valid),
    .alloc_select  (bus.alloc_select),
    .alloc_ready   (bus.alloc_ready),
    .wb_enable     (wb_enable_reg),
    .wb_select     (wb_select_reg),
    .src_a_select  (bus.src_a_select),
    .src_b_select  (bus.src_b_select),
    .src_a_busy    (bus.src_a_busy),
    .src_b_busy    (bus.src_b_busy),
    .pending       (bus.pending),
    .pending_count (bus.pending_count)
  );

endmodule

// File: tb/tb_mmx_writeback_controller.sv
// Directed bench for the MMX writeback controller: arbitration, write stage, scoreboard and async reset.
module tb_mmx_writeback_controller;
  import mmx_pkg::*;

  logic clk;
  logic reset;
  int   passed;
  int   total;

  localparam logic [63:0] DATA_B = 64'hDEAD_BEEF_0123_4567;
  localparam logic [63:0] DATA_X = 64'h1111_2222_3333_4444;
  localparam logic [63:0] DATA_M = 64'hAAAA_BBBB_CCCC_DDDD;
  localparam logic [63:0] DATA_5 = 64'h0505_0505_0505_0505;
  localparam logic [63:0] DATA_6 = 64'h6666_0000_6666_0000;
  localparam logic [63:0] DATA_R = 64'hFFFF_FFFF_0000_0001;

  mmx_writeback_controller_if bus ();

  mmx_writeback_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    reset  = 1'b0;
    bus.ex_wb_valid   = 1'b0;
    bus.ex_wb_select  = '0;
    bus.ex_wb_data    = '0;
    bus.mem_wb_valid  = 1'b0;
    bus.mem_wb_select = '0;
    bus.mem_wb_data   = '0;
    bus.alloc_valid   = 1'b0;
    bus.alloc_select  = '0;
    bus.src_a_select  = '0;
    bus.src_b_select  = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    next_cycle();

    // Reset / idle state
    chk("rst_wb_enable", 64'(bus.writeback_enable), 64'd0);
    chk("rst_wb_data",   bus.writeback_data, 64'd0);
    chk("rst_wb_select", 64'(bus.writeback_select), 64'd0);
    chk("rst_pending",   64'(bus.pending), 64'd0);
    chk("rst_count",     64'(bus.pending_count), 64'd0);
    chk("rst_ex_ready",  64'(bus.ex_wb_ready), 64'd0);
    chk("rst_mem_ready", 64'(bus.mem_wb_ready), 64'd0);

    // Allocate r3
    bus.alloc_valid  = 1'b1;
    bus.alloc_select = 3'd3;
    #1;
    chk("alloc3_ready", 64'(bus.alloc_ready), 64'd1);
    next_cycle();
    bus.alloc_valid  = 1'b0;
    bus.src_a_select = 3'd3;
    #1;
    chk("alloc3_pending", 64'(bus.pending), 64'h08);
    chk("alloc3_count",   64'(bus.pending_count), 64'd1);
    chk("alloc3_busy_a",  64'(bus.src_a_busy), 64'd1);
    chk("alloc3_busy_b",  64'(bus.src_b_busy), 64'd0);

    // EX only writes r3
    bus.ex_wb_valid  = 1'b1;
    bus.ex_wb_select = 3'd3;
    bus.ex_wb_data   = DATA_B;
    #1;
    chk("ex_only_ready",     64'(bus.ex_wb_ready), 64'd1);
    chk("ex_only_mem_ready", 64'(bus.mem_wb_ready), 64'd0);
    next_cycle();
    bus.ex_wb_valid = 1'b0;
    #1;
    chk("ex_only_wb_en",   64'(bus.writeback_enable), 64'd1);
    chk("ex_only_wb_sel",  64'(bus.writeback_select), 64'd3);
    chk("ex_only_wb_data", bus.writeback_data, DATA_B);
    chk("ex_only_pend_wb", 64'(bus.pending), 64'h08);
    next_cycle();
    chk("ex_only_pend_clr", 64'(bus.pending), 64'h00);
    chk("ex_only_count",    64'(bus.pending_count), 64'd0);
    chk("ex_only_busy_a",   64'(bus.src_a_busy), 64'd0);
    chk("ex_only_wb_idle",  64'(bus.writeback_enable), 64'd0);
    chk("ex_only_data_hold", bus.writeback_data, DATA_B);

    // Contention for 4 cycles: rr_ptr still at EX since no contended cycle yet
    bus.ex_wb_valid   = 1'b1;
    bus.ex_wb_select  = 3'd1;
    bus.ex_wb_data    = DATA_X;
    bus.mem_wb_valid  = 1'b1;
    bus.mem_wb_select = 3'd2;
    bus.mem_wb_data   = DATA_M;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr%0d_ex_ready", i),  64'(bus.ex_wb_ready),  (i % 2 == 0) ? 64'd1 : 64'd0);
      chk($sformatf("rr%0d_mem_ready", i), 64'(bus.mem_wb_ready), (i % 2 == 0) ? 64'd0 : 64'd1);
      if (i > 0) begin
        chk($sformatf("rr%0d_wb_sel", i), 64'(bus.writeback_select), (i % 2 == 1) ? 64'd1 : 64'd2);
        chk($sformatf("rr%0d_wb_data", i), bus.writeback_data, (i % 2 == 1) ? DATA_X : DATA_M);
      end
      next_cycle();
    end
    bus.ex_wb_valid  = 1'b0;
    bus.mem_wb_valid = 1'b0;
    #1;
    chk("rr_last_wb_en",  64'(bus.writeback_enable), 64'd1);
    chk("rr_last_wb_sel", 64'(bus.writeback_select), 64'd2);
    chk("rr_last_data",   bus.writeback_data, DATA_M);
    next_cycle();
    chk("rr_idle_wb_en", 64'(bus.writeback_enable), 64'd0);

    // WAW stall then set-wins on r5
    bus.alloc_valid  = 1'b1;
    bus.alloc_select = 3'd5;
    #1;
    chk("alloc5_first_ready", 64'(bus.alloc_ready), 64'd1);
    next_cycle();
    chk("alloc5_pending", 64'(bus.pending), 64'h20);
    chk("alloc5_stall",   64'(bus.alloc_ready), 64'd0);
    bus.alloc_valid  = 1'b0;
    bus.ex_wb_valid  = 1'b1;
    bus.ex_wb_select = 3'd5;
    bus.ex_wb_data   = DATA_5;
    #1;
    chk("wb5_ex_ready", 64'(bus.ex_wb_ready), 64'd1);
    next_cycle();
    bus.ex_wb_valid  = 1'b0;
    bus.alloc_valid  = 1'b1;
    bus.alloc_select = 3'd5;
    #1;
    chk("wb5_wb_en",       64'(bus.writeback_enable), 64'd1);
    chk("wb5_wb_sel",      64'(bus.writeback_select), 64'd5);
    chk("wb5_alloc_ready", 64'(bus.alloc_ready), 64'd1);
    next_cycle();
    bus.alloc_valid = 1'b0;
    #1;
    chk("setwins_pending", 64'(bus.pending), 64'h20);
    chk("setwins_count",   64'(bus.pending_count), 64'd1);

    // MEM writes r6 which is not pending
    bus.mem_wb_valid  = 1'b1;
    bus.mem_wb_select = 3'd6;
    bus.mem_wb_data   = DATA_6;
    #1;
    chk("mem6_ready",    64'(bus.mem_wb_ready), 64'd1);
    chk("mem6_ex_ready", 64'(bus.ex_wb_ready), 64'd0);
    next_cycle();
    bus.mem_wb_valid = 1'b0;
    #1;
    chk("mem6_wb_en",   64'(bus.writeback_enable), 64'd1);
    chk("mem6_wb_sel",  64'(bus.writeback_select), 64'd6);
    chk("mem6_wb_data", bus.writeback_data, DATA_6);
    next_cycle();
    chk("mem6_pending", 64'(bus.pending), 64'h20);
    chk("mem6_count",   64'(bus.pending_count), 64'd1);

    // Async reset mid-transfer
    bus.ex_wb_valid  = 1'b1;
    bus.ex_wb_select = 3'd5;
    bus.ex_wb_data   = DATA_R;
    next_cycle();
    bus.ex_wb_valid = 1'b0;
    chk("mid_wb_en_before", 64'(bus.writeback_enable), 64'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_wb_en",   64'(bus.writeback_enable), 64'd0);
    chk("mid_rst_wb_data", bus.writeback_data, 64'd0);
    chk("mid_rst_wb_sel",  64'(bus.writeback_select), 64'd0);
    chk("mid_rst_pending", 64'(bus.pending), 64'd0);
    chk("mid_rst_count",   64'(bus.pending_count), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    next_cycle();
    chk("post_rst_wb_en",   64'(bus.writeback_enable), 64'd0);
    chk("post_rst_pending", 64'(bus.pending), 64'd0);

    // rr_ptr returned to EX after reset
    bus.ex_wb_valid   = 1'b1;
    bus.mem_wb_valid  = 1'b1;
    #1;
    chk("post_rst_rr_ex",  64'(bus.ex_wb_ready), 64'd1);
    chk("post_rst_rr_mem", 64'(bus.mem_wb_ready), 64'd0);
    next_cycle();
    bus.ex_wb_valid  = 1'b0;
    bus.mem_wb_valid = 1'b0;
    next_cycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mmx_writeback_controller.md
Name: mmx_writeback_controller

Overview:
- Sequences all writes into the 8-entry, 64-bit MMX register file.
- Round-robin arbitrates two writeback requesters (EX pipe, MEM load return) over valid/ready handshakes and drives one registered write port into the file.
- Keeps an 8-bit pending scoreboard: set at destination allocation in decode, cleared at writeback. Decode uses it for RAW/WAW stalls.

Parameters:
- DATA_WIDTH, 64, width of an MMX register and of the writeback data.
- NUM_REGS, 8, number of MMX registers.
- SEL_WIDTH, 3, register select width (log2 NUM_REGS).

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- ex_wb_valid  in  1  EX writeback request.
- ex_wb_select  in  SEL_WIDTH  EX destination register.
- ex_wb_data  in  DATA_WIDTH  EX result.
- ex_wb_ready  out  1  EX request accepted this cycle (combinational).
- mem_wb_valid  in  1  MEM writeback request.
- mem_wb_select  in  SEL_WIDTH  MEM destination register.
- mem_wb_data  in  DATA_WIDTH  MEM load data.
- mem_wb_ready  out  1  MEM request accepted this cycle (combinational).
- alloc_valid  in  1  decode allocates a destination register.
- alloc_select  in  SEL_WIDTH  register being allocated.
- alloc_ready  out  1  allocation accepted (combinational).
- src_a_select, src_b_select  in  SEL_WIDTH each  decode source operands.
- src_a_busy, src_b_busy  out  1 each  source has an outstanding write.
- writeback_data  out  DATA_WIDTH  to register file (registered).
- writeback_select  out  SEL_WIDTH  to register file (registered).
- writeback_enable  out  1  to register file (registered).
- pending  out  NUM_REGS  scoreboard bits.
- pending_count  out  4  popcount of pending (0..8).

Behaviour:
- Reset (reset=0, async):
  - writeback_enable=0, writeback_data=0, writeback_select=0.
  - pending=0, pending_count=0.
  - Round-robin pointer rr_ptr=0, meaning EX has priority next.
  - If reset asserts mid-transfer, the staged write is discarded and the register file is not written.
- Arbitration (combinational grant):
  - Only EX valid: grant EX.
  - Only MEM valid: grant MEM.
  - Both valid: grant EX if rr_ptr=0, else MEM.
  - ex_wb_ready = grant_ex; mem_wb_ready = grant_mem.
  - Exactly one requester is accepted per cycle; the loser must hold valid, select and data stable until it is accepted.
  - rr_ptr updates only on a contended cycle (both valid). It points to the loser, so the loser wins the next contended cycle.
  - Maximum wait for a continuously valid requester is 1 cycle.
- Write stage (latency 1):
  - On an accepted request in cycle N, the next edge registers data and select and sets writeback_enable=1 during cycle N+1. The register file captures at the end of N+1.
  - With no acceptance, writeback_enable=0 the next cycle; data and select hold their previous values.
  - Back-to-back acceptance sustains 1 write per cycle.
- Scoreboard:
  - Set: an alloc handshake (alloc_valid & alloc_ready) sets pending[alloc_select] at the edge.
  - Clear: writeback_enable=1 clears pending[writeback_select] at the same edge the file is written.
  - Set and clear on the same register in the same cycle: set wins, leaving pending=1 for the new producer.
  - alloc_ready = ~pending[alloc_select] | (writeback_enable & writeback_select==alloc_select). This stalls WAW unless the old write retires this cycle.
  - Writeback to a register that is not pending: the data is still written and pending stays 0. No error is reported.
- Operand checks:
  - src_x_busy = pending[src_x_select]. There is no bypass: a source becomes non-busy the cycle after its write, which is the same cycle the file output shows the new value.
  - pending_count is registered and matches the pending vector each cycle.

Decomposition:
- Package mmx_pkg:
  - MMX_DATA_WIDTH=64, MMX_NUM_REGS=8, MMX_SEL_WIDTH=3.
  - Requester ids: REQ_EX=0, REQ_MEM=1.
- Sub-module mmx_scoreboard holds the pending vector, set/clear priority, alloc_ready, the busy lookups and pending_count.
- The top level holds the arbiter, rr_ptr and the write-stage registers.

Test Plan:
- Reset then idle: all outputs 0; alloc_valid=1, alloc_select=3 → alloc_ready=1, next cycle pending=8'h08, pending_count=1, src_a_select=3 gives src_a_busy=1.
- EX only, select=3, data=64'hDEAD_BEEF_0123_4567 → ex_wb_ready=1 same cycle; next cycle writeback_enable=1, select=3, that data; the following cycle pending[3]=0.
- EX and MEM both valid for 4 cycles from reset (EX sel 1, MEM sel 2) → grants EX, MEM, EX, MEM; writeback_select sequence 1, 2, 1, 2 with one-cycle lag.
- pending[5]=1 and alloc_select=5 with no writeback → alloc_ready=0. In the cycle writeback_enable=1, select=5 → alloc_ready=1; after the edge pending[5] stays 1 (set wins).
- Assert reset low for half a cycle while writeback_enable=1 → outputs immediately 0, pending cleared, no file write at the next edge.
- MEM writes to register 6 while pending[6]=0 → write occurs, pending stays 0, pending_count unchanged.
